// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and default sizing.
// Imported by the arbiter top and its starvation counter.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned STARVE_DEF = 4;
   localparam int unsigned CNT_W      = 4;   // holds STARVE up to 15

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arbState_t;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of edges the fetch side has waited without being granted.
// sat flags that fetch must win the next arbitration.
module starve_counter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE = STARVE_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sat = (cnt == CNT_W'(STARVE));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main memory between instruction refill and the data stage.
// Data has priority unless the fetch side has starved for STARVE edges.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned STARVE = STARVE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ifReq,
   input  logic [8:0]        ifAddr,
   input  logic              flush,
   input  logic              dReq,
   input  logic              dWrite,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] dWdata,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              memReady,
   output logic [DATA_W-1:0] ifRdata,
   output logic              ifValid,
   output logic              ifStall,
   output logic [DATA_W-1:0] dRdata,
   output logic              dValid,
   output logic              dStall
);

   arbState_t         state, stateNext;
   logic              drop, dropNext;
   logic              memReqNext, memWeNext;
   logic [ADDR_W-1:0] memAddrNext;
   logic [DATA_W-1:0] memWdataNext, ifRdataNext, dRdataNext;
   logic              ifValidNext, dValidNext;
   logic              enterI, starveSat;

   starve_counter #(.STARVE(STARVE)) uStarve (
      .clk   (clk),
      .reset (reset),
      .inc   (ifReq && !enterI),
      .clr   (enterI),
      .sat   (starveSat)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         drop  <= 1'b0;
      end else begin
         state <= stateNext;
         drop  <= dropNext;
      end
   end

   always_comb begin
      stateNext    = state;
      dropNext     = drop;
      enterI       = 1'b0;
      memReqNext   = memReq;
      memWeNext    = memWe;
      memAddrNext  = memAddr;
      memWdataNext = memWdata;
      ifRdataNext  = ifRdata;
      dRdataNext   = dRdata;
      ifValidNext  = 1'b0;
      dValidNext   = 1'b0;

      case (state)
         IDLE: begin
            dropNext = 1'b0;
            if (dReq && !(ifReq && starveSat)) begin
               stateNext    = GRANT_D;
               memReqNext   = 1'b1;
               memWeNext    = dWrite;
               memAddrNext  = dAddr;
               memWdataNext = dWrite ? dWdata : '0;
            end else if (ifReq) begin
               stateNext   = GRANT_I;
               enterI      = 1'b1;
               memReqNext  = 1'b1;
               memWeNext   = 1'b0;
               memAddrNext = ADDR_W'(ifAddr);
            end
         end

         GRANT_I: begin
            if (memReady) begin
               stateNext  = IDLE;
               memReqNext = 1'b0;
               memWeNext  = 1'b0;
               dropNext   = 1'b0;
               // A flush on the completing cycle itself still discards the word.
               if (!(drop || flush)) begin
                  ifValidNext = 1'b1;
                  ifRdataNext = memRdata;
               end
            end else if (flush) begin
               dropNext = 1'b1;
            end
         end

         GRANT_D: begin
            if (memReady) begin
               stateNext  = IDLE;
               memReqNext = 1'b0;
               memWeNext  = 1'b0;
               dValidNext = 1'b1;
               if (!memWe) begin
                  dRdataNext = memRdata;
               end
            end
         end

         default: begin
            stateNext  = IDLE;
            memReqNext = 1'b0;
            memWeNext  = 1'b0;
            dropNext   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         memReq   <= 1'b0;
         memWe    <= 1'b0;
         memAddr  <= '0;
         memWdata <= '0;
         ifRdata  <= '0;
         ifValid  <= 1'b0;
         dRdata   <= '0;
         dValid   <= 1'b0;
      end else begin
         memReq   <= memReqNext;
         memWe    <= memWeNext;
         memAddr  <= memAddrNext;
         memWdata <= memWdataNext;
         ifRdata  <= ifRdataNext;
         ifValid  <= ifValidNext;
         dRdata   <= dRdataNext;
         dValid   <= dValidNext;
      end
   end

   assign ifStall = ifReq & ~ifValid;
   assign dStall  = dReq & ~dValid;

endmodule
